alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, sequential successor to the team's 8-bit combinational ALU. It keeps the 4-bit opcode map and the dual-result outputs: `x` carries the primary result, and `y` carries the secondary result (high half, remainder, carry or compare). It adds valid/ready handshakes on both sides, registered outputs, status flags, and an iterative multi-cycle divider. It sits between an instruction/operand source and a result consumer, and processes one operation at a time.

## Interface
- `WIDTH`, 8: operand and result width. Must be at least 4.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset. Only one clock domain exists.
- `in_valid` in 1: the operand beat is valid.
- `in_ready` out 1: the block can accept a beat.
- `opcode` in 4: operation select.
- `a`, `b` in WIDTH: operands.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `x`, `y` out WIDTH: primary and secondary results.
- `flags` out 4: {zero, neg, carry, ovf}, taken from `x`.
- `err` out 1: the operation was illegal (divide by zero, or a disabled opcode).

## Operation
- States and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, latch `opcode`, `a` and `b`. Opcode 0011 (with the divider enabled) goes to BUSY. All other opcodes compute and go to DONE.
  - BUSY: runs the divider. Goes to DONE after the divider completes.
  - DONE: `out_valid`=1. Goes back to IDLE when `out_ready`=1.
- Opcode map:
  - 0000 ADD: x=a+b, y=carry.
  - 0001 SUB: x=a-b, y=borrow.
  - 0010 MUL: {y,x}=a*b, unsigned, 2·WIDTH bits.
  - 0011 DIV: x=a/b, y=a%b, unsigned.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR: result in x; y=0.
  - 1000 NOT: x=~a; y=0.
  - 1001 SHL, 1010 SHR (logical), 1011 SRA, 1100 ROL: a shifted by b[$clog2(WIDTH)-1:0]; y=0.
  - 1101 INC: x=a+1, y=carry.
  - 1110 DEC: x=a-1, y=borrow.
  - 1111 CMP: x[2:0]={a>b, a==b, a<b} unsigned, y[2:0] the same comparison signed; all other bits 0.
- Flags:
  - zero = (x==0).
  - neg = x[WIDTH-1].
  - carry = the carry/borrow for ADD/SUB/INC/DEC, 0 otherwise.
  - ovf = two's-complement overflow for ADD/SUB/INC/DEC; for MUL, ovf = (y!=0); 0 otherwise.
- Divide by zero: x=all ones, y=a, err=1. It completes single-cycle and never enters BUSY.
- Arithmetic is modulo 2^WIDTH and wraps silently. Overflow is reported only through `flags`.

## Timing
- Reset values: `in_ready`=0 during reset and 1 on the first cycle after release; `out_valid`=0; `x`=0; `y`=0; `flags`=0; `err`=0. The state is IDLE.
- Non-divide ops: accepted at edge N, `out_valid`=1 after edge N+1.
- DIV: accepted at edge N, `out_valid`=1 after edge N+WIDTH+1. This is one restoring step per cycle.
- `x`, `y`, `flags` and `err` are stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is low in BUSY and DONE, so there is no overlap of operations. The next beat can be accepted on the cycle after the output handshake completes.
- Reset during BUSY or DONE aborts the operation. The result is discarded, and every output returns to its reset value on the next edge.
- Inputs are sampled only on the accept edge. Changes while the block is not ready are ignored.

## Configuration
- Macro `ALU_SEQ_DIV_EN`.
- Defined: the iterative divider is instantiated and opcode 0011 behaves as specified above.
- Undefined: no divider logic is built. Opcode 0011 completes single-cycle with x=0, y=0, err=1.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode localparams (OP_ADD … OP_CMP);
  - the state enum (IDLE, BUSY, DONE);
  - the flag bit indices.
- Sub-module `alu_seq_div`: an iterative restoring divider, parametrised by WIDTH, with a start/done handshake to the parent FSM.

## Test plan
- ADD, WIDTH=8, a=0x0A, b=0x05 -> x=0x0F, y=0x00, flags=0000, `out_valid` exactly 1 cycle after accept.
- MUL, a=0xFF, b=0xFF -> x=0x01, y=0xFE, ovf=1. ADD 0x7F+0x01 -> x=0x80, neg=1, ovf=1.
- DIV, a=0x0A, b=0x05 (macro defined) -> x=0x02, y=0x00, `out_valid` 9 cycles after accept, `in_ready` low throughout.
- DIV, b=0x00 -> x=0xFF, y=0x0A, err=1, single-cycle latency. With the macro undefined, DIV 0x0A/0x05 -> x=0, y=0, err=1.
- Back-pressure: hold `out_ready`=0 for 3 cycles after a CMP of a=0xFF, b=0x00 -> x=0x04, y=0x01 held stable, `in_ready`=0 until the handshake.
- Reset: assert `rst_n`=0 at cycle 4 of a DIV -> next edge `out_valid`=0, x=y=0. After release, an ADD completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and flag bit positions.
// Used by both alu_seq and alu_seq_div; the ALU_SEQ_DIV_EN macro is consumed by alu_seq only.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;
  localparam logic [3:0] OP_ROL = 4'hC;
  localparam logic [3:0] OP_INC = 4'hD;
  localparam logic [3:0] OP_DEC = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH steps after start_i.
// done_o is high for exactly one cycle once the final step has been taken.
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    count_q;
  logic             run_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // A set top bit of trial means the divisor did not fit, so the shifted remainder is kept.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (start_i) begin
      quot_q  <= dividend_i;
      rem_q   <= '0;
      dvsr_q  <= divisor_i;
      count_q <= CW'(WIDTH);
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (count_q != '0) begin
        if (!trial[WIDTH]) begin
          rem_q  <= trial[WIDTH-1:0];
          quot_q <= {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q  <= shifted[WIDTH-1:0];
          quot_q <= {quot_q[WIDTH-2:0], 1'b0};
        end
        count_q <= count_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o = run_q && (count_q == '0);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides, registered results and status flags.
// Define ALU_SEQ_DIV_EN to build the iterative divider; otherwise DIV reports err.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic             in_ready_q, out_valid_q, err_q;
  logic [3:0]       op_q, flags_q, flags_d;
  logic [WIDTH-1:0] a_q, b_q, x_q, y_q;
  logic             accept, load_res;
  logic             div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  logic [WIDTH-1:0]   res_x, res_y, nx, ny;
  logic               res_c, res_v, res_err, nc, nv, nerr;
  logic [WIDTH:0]     sum_ext, diff_ext, inc_ext, dec_ext;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]     sh;
  logic [SHW:0]       rsh;

  assign accept = in_valid && in_ready_q;

`ifdef ALU_SEQ_DIV_EN
  logic div_start;

  // Divide by zero never reaches the divider; it resolves on the single-cycle path.
  assign div_start = (state_q == IDLE) && accept && (opcode == OP_DIV) && (b != '0);

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (a),
    .divisor_i  (b),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );
`else
  assign div_done = 1'b0;
  assign div_quot = '0;
  assign div_rem  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DONE spends one cycle computing from the latched operands before out_valid rises.
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_DIV_EN
          if (div_start) state_d = BUSY;
          else           state_d = DONE;
`else
          state_d = DONE;
`endif
        end
      end
      BUSY: begin
        if (div_done) begin
          state_d  = DONE;
          load_res = 1'b1;
        end
      end
      DONE: begin
        if (!out_valid_q)   load_res = 1'b1;
        else if (out_ready) state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh       = b_q[SHW-1:0];
    rsh      = (SHW+1)'(WIDTH) - {1'b0, sh};
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    inc_ext  = {1'b0, a_q} + (WIDTH+1)'(1);
    dec_ext  = {1'b0, a_q} - (WIDTH+1)'(1);
    prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    res_x    = '0;
    res_y    = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    res_err  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_x = sum_ext[MSB:0];
        res_c = sum_ext[WIDTH];
        res_y = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
        res_v = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        res_x = diff_ext[MSB:0];
        res_c = diff_ext[WIDTH];
        res_y = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
        res_v = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
      end
      OP_MUL: begin
        res_x = prod[MSB:0];
        res_y = prod[2*WIDTH-1:WIDTH];
        res_v = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        res_x   = '1;
        res_y   = a_q;
        res_err = 1'b1;
`else
        res_err = 1'b1;
`endif
      end
      OP_AND: res_x = a_q & b_q;
      OP_OR:  res_x = a_q | b_q;
      OP_XOR: res_x = a_q ^ b_q;
      OP_NOR: res_x = ~(a_q | b_q);
      OP_NOT: res_x = ~a_q;
      OP_SHL: res_x = a_q << sh;
      OP_SHR: res_x = a_q >> sh;
      OP_SRA: res_x = $signed(a_q) >>> sh;
      OP_ROL: res_x = (a_q << sh) | (a_q >> rsh);
      OP_INC: begin
        res_x = inc_ext[MSB:0];
        res_c = inc_ext[WIDTH];
        res_y = {{(WIDTH-1){1'b0}}, inc_ext[WIDTH]};
        res_v = !a_q[MSB] && inc_ext[MSB];
      end
      OP_DEC: begin
        res_x = dec_ext[MSB:0];
        res_c = dec_ext[WIDTH];
        res_y = {{(WIDTH-1){1'b0}}, dec_ext[WIDTH]};
        res_v = a_q[MSB] && !dec_ext[MSB];
      end
      OP_CMP: begin
        res_x = {{(WIDTH-3){1'b0}}, a_q > b_q, a_q == b_q, a_q < b_q};
        res_y = {{(WIDTH-3){1'b0}}, $signed(a_q) > $signed(b_q),
                 a_q == b_q, $signed(a_q) < $signed(b_q)};
      end
      default: ;
    endcase
  end

  always_comb begin
    if (state_q == BUSY) begin
      nx   = div_quot;
      ny   = div_rem;
      nc   = 1'b0;
      nv   = 1'b0;
      nerr = 1'b0;
    end else begin
      nx   = res_x;
      ny   = res_y;
      nc   = res_c;
      nv   = res_v;
      nerr = res_err;
    end
    flags_d             = '0;
    flags_d[FLAG_ZERO]  = (nx == '0);
    flags_d[FLAG_NEG]   = nx[MSB];
    flags_d[FLAG_CARRY] = nc;
    flags_d[FLAG_OVF]   = nv;
  end

  // Results only load once per operation, so they hold steady under back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        op_q <= opcode;
        a_q  <= a;
        b_q  <= b;
      end
      if (load_res) begin
        x_q         <= nx;
        y_q         <= ny;
        flags_q     <= flags_d;
        err_q       <= nerr;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed table, multi-cycle corner sequences,
// and randomized operations against an integer reference model; honours ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] f;
    logic       e;
    int         lat;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]   opcode, flags;
  logic [W-1:0] a, b, x, y;

  int total  = 0;
  int passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .flags     (flags),
    .err       (err)
  );

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Integer model: results from plain arithmetic on unsigned/signed interpretations.
  function automatic res_t refModel(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    res_t r;
    int ua, ub, sa, sb, t, sh;
    logic c, v;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sh = ub % 8;
    t = 0; c = 1'b0; v = 1'b0;
    r.y = 8'h00; r.e = 1'b0; r.lat = 1;
    case (op)
      4'h0: begin t = ua + ub; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'h1: begin t = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'h2: begin t = ua * ub; r.y = 8'(t / 256); v = (t / 256) != 0; end
      4'h3: begin
`ifdef ALU_SEQ_DIV_EN
        if (ub == 0) begin t = 255; r.y = av; r.e = 1'b1; end
        else begin t = ua / ub; r.y = 8'(ua % ub); r.lat = W + 1; end
`else
        t = 0; r.e = 1'b1;
`endif
      end
      4'h4: t = ua & ub;
      4'h5: t = ua | ub;
      4'h6: t = ua ^ ub;
      4'h7: t = ~(ua | ub);
      4'h8: t = ~ua;
      4'h9: t = ua << sh;
      4'hA: t = ua >> sh;
      4'hB: t = sa >>> sh;
      4'hC: t = (ua << sh) | (ua >> (8 - sh));
      4'hD: begin t = ua + 1; c = (ua == 255); v = (sa + 1 > 127); end
      4'hE: begin t = ua - 1; c = (ua == 0); v = (sa - 1 < -128); end
      default: begin
        t   = (ua > ub ? 4 : 0) + (ua == ub ? 2 : 0) + (ua < ub ? 1 : 0);
        r.y = 8'((sa > sb ? 4 : 0) + (sa == sb ? 2 : 0) + (sa < sb ? 1 : 0));
      end
    endcase
    if (op == 4'h0 || op == 4'h1 || op == 4'hD || op == 4'hE) r.y = {7'b0, c};
    r.x = t[7:0];
    r.f = {r.x == 8'h00, r.x[7], c, v};
    return r;
  endfunction

  // One full transaction with out_ready high; caller sits #1 after a rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                               output res_t got, output logic irLeak);
    int guard;
    guard  = 0;
    irLeak = 1'b0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    opcode = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    got.lat = 0;
    while (!out_valid && got.lat < 40) begin
      if (in_ready) irLeak = 1'b1;
      @(posedge clk); #1;
      got.lat++;
    end
    got.x = x; got.y = y; got.f = flags; got.e = err;
    @(posedge clk); #1;
  endtask

  function automatic void addVec(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] ex, input logic [7:0] ey, input logic [3:0] ef,
                                 input logic ee, input int el);
    vec_t v;
    v.op = op; v.a = av; v.b = bv;
    v.exp.x = ex; v.exp.y = ey; v.exp.f = ef; v.exp.e = ee; v.exp.lat = el;
    vecs.push_back(v);
  endfunction

  initial begin
    res_t got, exp;
    logic leak;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    addVec(4'h0, 8'h0A, 8'h05, 8'h0F, 8'h00, 4'b0000, 1'b0, 1);
    addVec(4'h2, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0001, 1'b0, 1);
    addVec(4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0101, 1'b0, 1);
    addVec(4'h1, 8'h05, 8'h0A, 8'hFB, 8'h01, 4'b0110, 1'b0, 1);
    addVec(4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001, 1'b0, 1);
    addVec(4'hD, 8'hFF, 8'h00, 8'h00, 8'h01, 4'b1010, 1'b0, 1);
    addVec(4'hE, 8'h00, 8'h00, 8'hFF, 8'h01, 4'b0110, 1'b0, 1);
    addVec(4'hB, 8'h80, 8'h03, 8'hF0, 8'h00, 4'b0100, 1'b0, 1);
    addVec(4'hC, 8'h81, 8'h01, 8'h03, 8'h00, 4'b0000, 1'b0, 1);
    addVec(4'h9, 8'h01, 8'h0F, 8'h80, 8'h00, 4'b0100, 1'b0, 1);
    addVec(4'h7, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0100, 1'b0, 1);
    addVec(4'hF, 8'hFF, 8'h00, 8'h04, 8'h01, 4'b0000, 1'b0, 1);
`ifdef ALU_SEQ_DIV_EN
    addVec(4'h3, 8'h0A, 8'h05, 8'h02, 8'h00, 4'b0000, 1'b0, 9);
    addVec(4'h3, 8'h0A, 8'h00, 8'hFF, 8'h0A, 4'b0100, 1'b1, 1);
`else
    addVec(4'h3, 8'h0A, 8'h05, 8'h00, 8'h00, 4'b1000, 1'b1, 1);
    addVec(4'h3, 8'h0A, 8'h00, 8'h00, 8'h00, 4'b1000, 1'b1, 1);
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'h0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, got, leak);
      checkOutput($sformatf("vec%0d_x", i), 32'(got.x), 32'(vecs[i].exp.x));
      checkOutput($sformatf("vec%0d_y", i), 32'(got.y), 32'(vecs[i].exp.y));
      checkOutput($sformatf("vec%0d_flags", i), 32'(got.f), 32'(vecs[i].exp.f));
      checkOutput($sformatf("vec%0d_err", i), 32'(got.e), 32'(vecs[i].exp.e));
      checkOutput($sformatf("vec%0d_latency", i), 32'(got.lat), 32'(vecs[i].exp.lat));
      checkOutput($sformatf("vec%0d_in_ready_low", i), 32'(leak), 32'd0);
    end

    // Back-pressure: CMP result must hold while out_ready is low; new beats are ignored.
    out_ready = 1'b0;
    opcode = 4'hF; a = 8'hFF; b = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d_x", k), 32'(x), 32'h04);
      checkOutput($sformatf("bp%0d_y", k), 32'(y), 32'h01);
      checkOutput($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      in_valid = 1'b1; opcode = 4'h0; a = 8'h01; b = 8'h01;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_hold_x", 32'(x), 32'h04);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a DIV must discard it and clear every output.
    out_ready = 1'b0;
    opcode = 4'h3; a = 8'h0A; b = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_x", 32'(x), 32'd0);
    checkOutput("midrst_y", 32'(y), 32'd0);
    checkOutput("midrst_flags", 32'(flags), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_release_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(4'h0, 8'h0A, 8'h05, got, leak);
    checkOutput("post_rst_add_x", 32'(got.x), 32'h0F);
    checkOutput("post_rst_add_latency", 32'(got.lat), 32'd1);
    exp = refModel(4'h3, 8'h64, 8'h07);
    applyStimulus(4'h3, 8'h64, 8'h07, got, leak);
    checkOutput("post_rst_div_x", 32'(got.x), 32'(exp.x));
    checkOutput("post_rst_div_y", 32'(got.y), 32'(exp.y));
    checkOutput("post_rst_div_latency", 32'(got.lat), 32'(exp.lat));

    for (int n = 0; n < 300; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      exp = refModel(rop, ra, rb);
      applyStimulus(rop, ra, rb, got, leak);
      checkOutput($sformatf("rnd%0d_op%0h_x", n, rop), 32'(got.x), 32'(exp.x));
      checkOutput($sformatf("rnd%0d_op%0h_y", n, rop), 32'(got.y), 32'(exp.y));
      checkOutput($sformatf("rnd%0d_op%0h_flags", n, rop), 32'(got.f), 32'(exp.f));
      checkOutput($sformatf("rnd%0d_op%0h_err", n, rop), 32'(got.e), 32'(exp.e));
      checkOutput($sformatf("rnd%0d_op%0h_latency", n, rop), 32'(got.lat), 32'(exp.lat));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
